// File: rtl/light_pattern_serializer.sv
// Serial output stage for the weddinglight pattern generator.
// Accepts one WIDTH-bit pattern word over a valid/ready handshake.
// Shifts the word out to a 74HC595-style driver as ser_data/ser_clk,
// then pulses ser_latch and signals frame_done. All outputs are registered.
module light_pattern_serializer #(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy,
  output logic             frame_done
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [WIDTH-1:0]   shadow, shadow_n;
  logic               ready_n, data_n, clk_n, latch_n, busy_n, done_n;
  logic               last_div;

  // Select the bit-th bit to be shifted, honouring the configured bit order.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [BIT_W-1:0] b);
    logic [BIT_W-1:0] idx;
    idx = MSB_FIRST ? (BIT_W'(WIDTH - 1) - b) : b;
    return w[idx];
  endfunction

  assign last_div = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Next-state, counter and registered-output decode; outputs follow the state being entered.
  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    shadow_n = shadow;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n  = SETUP;
          shadow_n = in_data;
          bit_n    = '0;
          div_n    = '0;
        end
      end
      SETUP: begin
        if (last_div) begin
          div_n   = '0;
          state_n = HIGH;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      HIGH: begin
        if (last_div) begin
          div_n = '0;
          if (bit_cnt == BIT_W'(WIDTH - 1)) begin
            state_n = LATCH;
          end else begin
            bit_n   = bit_cnt + BIT_W'(1);
            state_n = SETUP;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      LATCH: begin
        if (last_div) begin
          div_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
    clk_n   = (state_n == HIGH);
    latch_n = (state_n == LATCH);
    data_n  = ((state_n == SETUP) || (state_n == HIGH)) ? pick_bit(shadow_n, bit_n) : 1'b0;
  end

  // State, counters, shadow word and output registers; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shadow     <= '0;
      in_ready   <= 1'b1;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      shadow     <= shadow_n;
      in_ready   <= ready_n;
      ser_data   <= data_n;
      ser_clk    <= clk_n;
      ser_latch  <= latch_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_light_pattern_serializer.sv
// Bench for light_pattern_serializer: a default instance (MSB first, CLK_DIV=4)
// and an LSB-first CLK_DIV=1 instance, checked every cycle against a frame-time model.
module tb_light_pattern_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [15:0] din [2];
  logic [1:0]  rdy, bsy, sclk, sdat, slat, fdone;

  always #5 clk = ~clk;

  light_pattern_serializer #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .ser_data(sdat[0]), .ser_clk(sclk[0]), .ser_latch(slat[0]), .busy(bsy[0]),
    .frame_done(fdone[0]));

  light_pattern_serializer #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .ser_data(sdat[1]), .ser_clk(sclk[1]), .ser_latch(slat[1]), .busy(bsy[1]),
    .frame_done(fdone[1]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Frame-time model: a frame is just "t cycles since accept" plus the word.
  bit          m_act  [2];
  int          m_t    [2];
  logic [15:0] m_word [2];
  bit          m_done [2];

  // Monitor state
  logic [15:0] cap [2];
  int rises [2], latch_cyc [2], latch_pul [2], done_cnt [2], done_cyc [2];
  int last_rise [2], prev_rise [2];
  logic [1:0] pclk, plat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int d;
      d = div_of(i);
      if (rst) begin
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else if (!m_act[i] && vld[i]) begin
        m_act[i]  = 1'b1;
        m_t[i]    = 0;
        m_word[i] = din[i];
        m_done[i] = 1'b0;
      end else if (m_act[i]) begin
        m_t[i]++;
        if (m_t[i] == 2 * 16 * d + d) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int d, t, bi;
        logic e_rdy, e_bsy, e_clk, e_dat, e_lat, e_done;
        d = div_of(i);
        e_rdy = 1'b1; e_bsy = 1'b0; e_clk = 1'b0; e_dat = 1'b0; e_lat = 1'b0; e_done = m_done[i];
        if (m_act[i]) begin
          t = m_t[i];
          e_rdy = 1'b0; e_bsy = 1'b1; e_done = 1'b0;
          if (t < 2 * 16 * d) begin
            bi    = t / (2 * d);
            e_clk = ((t % (2 * d)) >= d);
            e_dat = (i == 0) ? m_word[i][15 - bi] : m_word[i][bi];
          end else begin
            e_lat = 1'b1;
          end
        end
        chk($sformatf("u%0d in_ready cyc%0d", i, cyc), rdy[i], e_rdy);
        chk($sformatf("u%0d busy cyc%0d", i, cyc), bsy[i], e_bsy);
        chk($sformatf("u%0d ser_clk cyc%0d", i, cyc), sclk[i], e_clk);
        chk($sformatf("u%0d ser_data cyc%0d", i, cyc), sdat[i], e_dat);
        chk($sformatf("u%0d ser_latch cyc%0d", i, cyc), slat[i], e_lat);
        chk($sformatf("u%0d frame_done cyc%0d", i, cyc), fdone[i], e_done);
        if (sclk[i] && !pclk[i]) begin
          cap[i] = {cap[i][14:0], sdat[i]};
          rises[i]++;
          prev_rise[i] = last_rise[i];
          last_rise[i] = cyc;
        end
        if (slat[i]) latch_cyc[i]++;
        if (slat[i] && !plat[i]) latch_pul[i]++;
        if (fdone[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        pclk[i] = sclk[i];
        plat[i] = slat[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int start, input int maxc, input string name);
    int n;
    n = 0;
    while (done_cnt[i] == start && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, " frame_done seen"}, 32'(done_cnt[i] != start), 32'd1);
  endtask

  initial begin
    int acc, r0, l0, p0, d0, dc1, n;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_word[i] = '0; m_done[i] = 1'b0;
      cap[i] = '0; rises[i] = 0; latch_cyc[i] = 0; latch_pul[i] = 0;
      done_cnt[i] = 0; done_cyc[i] = 0; last_rise[i] = 0; prev_rise[i] = 0;
    end
    pclk = '0; plat = '0;
    rst = 1'b1; vld = '0; din[0] = '0; din[1] = '0;

    // Reset values
    tick(); tick();
    chk("rst in_ready", rdy[0], 1); chk("rst busy", bsy[0], 0);
    chk("rst ser_clk", sclk[0], 0); chk("rst ser_data", sdat[0], 0);
    chk("rst ser_latch", slat[0], 0); chk("rst frame_done", fdone[0], 0);
    chk("rst u1 in_ready", rdy[1], 1);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(); tick();

    // Single frame A5C3, MSB first
    r0 = rises[0]; l0 = latch_cyc[0]; d0 = done_cnt[0];
    din[0] = 16'hA5C3; vld[0] = 1'b1;
    tick();
    acc = cyc; vld[0] = 1'b0;
    wait_done(0, d0, 300, "t2");
    chk("t2 shifted bits", cap[0], 16'hA5C3);
    chk("t2 ser_clk rises", rises[0] - r0, 16);
    chk("t2 latch cycles", latch_cyc[0] - l0, 4);
    chk("t2 done latency", done_cyc[0] - acc, 132);

    // in_valid held through a frame; second word accepted in the frame_done cycle
    tick();
    d0 = done_cnt[0];
    din[0] = 16'h8001; vld[0] = 1'b1;
    tick();
    din[0] = 16'h00FF;
    wait_done(0, d0, 300, "t3a");
    chk("t3 first word", cap[0], 16'h8001);
    chk("t3 ready in done cycle", rdy[0], 1);
    dc1 = done_cyc[0]; d0 = done_cnt[0];
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk); #1;
    chk("t3 no gap busy", bsy[0], 1);
    wait_done(0, d0, 300, "t3b");
    chk("t3 second word", cap[0], 16'h00FF);
    chk("t3 back-to-back spacing", done_cyc[0] - dc1, 133);

    // Reset mid-frame after 8th rise
    tick();
    r0 = rises[0]; p0 = latch_pul[0]; d0 = done_cnt[0];
    din[0] = 16'hFFFF; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    n = 0;
    while ((rises[0] - r0) < 8 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("t4 reached 8 rises", rises[0] - r0, 8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4 busy after rst", bsy[0], 0);
    chk("t4 ready after rst", rdy[0], 1);
    repeat (150) tick();
    chk("t4 no latch pulse", latch_pul[0] - p0, 0);
    chk("t4 no frame_done", done_cnt[0] - d0, 0);
    d0 = done_cnt[0];
    din[0] = 16'h1234; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    wait_done(0, d0, 300, "t4");
    chk("t4 shifted bits", cap[0], 16'h1234);

    // LSB first, CLK_DIV=1
    tick();
    r0 = rises[1]; d0 = done_cnt[1];
    din[1] = 16'h0001; vld[1] = 1'b1;
    tick();
    acc = cyc; vld[1] = 1'b0;
    wait_done(1, d0, 100, "t5");
    chk("t5 shifted bits", cap[1], 16'h8000);
    chk("t5 ser_clk rises", rises[1] - r0, 16);
    chk("t5 ser_clk period", last_rise[1] - prev_rise[1], 2);
    chk("t5 done latency", done_cyc[1] - acc, 33);

    // FFFF then 0000 back-to-back
    tick();
    r0 = rises[0]; p0 = latch_pul[0]; d0 = done_cnt[0];
    din[0] = 16'hFFFF; vld[0] = 1'b1;
    tick();
    din[0] = 16'h0000;
    wait_done(0, d0, 300, "t6a");
    chk("t6 first word", cap[0], 16'hFFFF);
    d0 = done_cnt[0];
    @(posedge clk); #1;
    vld[0] = 1'b0;
    wait_done(0, d0, 300, "t6b");
    chk("t6 second word", cap[0], 16'h0000);
    chk("t6 ser_clk rises", rises[0] - r0, 32);
    chk("t6 latch pulses", latch_pul[0] - p0, 2);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
